// File: rtl/run_pkg.sv
// Shared types and encodings for the run sequencer; the STATUS_* codes are
// also consumed by slowclock for its clock selection.
package run_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RX,
      S_PROC,
      S_TX,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [1:0] STATUS_IDLE = 2'b00;
   localparam logic [1:0] STATUS_RX   = 2'b01;
   localparam logic [1:0] STATUS_PROC = 2'b10;
   localparam logic [1:0] STATUS_TX   = 2'b11;

   localparam logic [3:0] LED_IDLE  = 4'b0001;
   localparam logic [3:0] LED_RX    = 4'b0010;
   localparam logic [3:0] LED_PROC  = 4'b0100;
   localparam logic [3:0] LED_TX    = 4'b1000;
   localparam logic [3:0] LED_DONE  = 4'b1111;
   localparam logic [3:0] LED_ERROR = 4'b1001;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_RX   = 2'b01;
   localparam logic [1:0] ERR_PROC = 2'b10;
   localparam logic [1:0] ERR_TX   = 2'b11;

   // DONE and ERROR share the idle clock selection
   function automatic logic [1:0] statusOf(input state_t s);
      case (s)
         S_RX:    return STATUS_RX;
         S_PROC:  return STATUS_PROC;
         S_TX:    return STATUS_TX;
         default: return STATUS_IDLE;
      endcase
   endfunction

   function automatic logic [3:0] ledOf(input state_t s);
      case (s)
         S_RX:    return LED_RX;
         S_PROC:  return LED_PROC;
         S_TX:    return LED_TX;
         S_DONE:  return LED_DONE;
         S_ERROR: return LED_ERROR;
         default: return LED_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/run_sequencer_if.sv
// Control/handshake bundle between the run sequencer and the rest of the
// down-sampling system.
interface run_sequencer_if #(
   parameter int FRAME_W = 8
);
   logic               start_process;
   logic [1:0]         mode;
   logic [FRAME_W-1:0] frame_count;
   logic               abort;
   logic               clear_err;
   logic               rx_done;
   logic               end_process;
   logic               tx_done;

   logic               rx_start;
   logic               proc_start;
   logic               tx_start;
   logic [1:0]         status;
   logic [3:0]         phase_led;
   logic [FRAME_W-1:0] frame_idx;
   logic               run_done;
   logic [1:0]         err_code;

   modport master (
      output start_process, mode, frame_count, abort, clear_err,
             rx_done, end_process, tx_done,
      input  rx_start, proc_start, tx_start, status, phase_led,
             frame_idx, run_done, err_code
   );

   modport slave (
      input  start_process, mode, frame_count, abort, clear_err,
             rx_done, end_process, tx_done,
      output rx_start, proc_start, tx_start, status, phase_led,
             frame_idx, run_done, err_code
   );
endinterface

// File: rtl/phase_watchdog.sv
// Per-phase cycle counter; flags expiry on the last allowed cycle of a phase.
module phase_watchdog #(
   parameter int              TO_W           = 24,
   parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam logic [TO_W-1:0] LIMIT   = TIMEOUT_CYCLES - TO_W'(1);
   localparam logic            ENABLED = (TIMEOUT_CYCLES != '0);

   logic [TO_W-1:0] r_count;
   logic [TO_W-1:0] w_current;

   // The clear arrives with the entry pulse, so the entry cycle itself counts as zero
   assign w_current = i_clear ? '0 : r_count;
   assign o_expired = ENABLED && i_enable && (w_current == LIMIT);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= w_current + TO_W'(1);
      end else begin
         r_count <= '0;
      end
   end

endmodule

// File: rtl/run_sequencer.sv
// Frame run controller: RX -> PROC -> TX per frame with bypass, repeat count,
// per-phase watchdog, abort and error hold.
module run_sequencer
   import run_pkg::*;
#(
   parameter int              FRAME_W        = 8,
   parameter int              TO_W           = 24,
   parameter logic [TO_W-1:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
   input  logic            clock,
   input  logic            reset_n,
   run_sequencer_if.slave  bus
);

   state_t             r_state;
   logic [1:0]         r_status;
   logic [3:0]         r_led;
   logic               r_rxStart;
   logic               r_procStart;
   logic               r_txStart;
   logic               r_runDone;
   logic [1:0]         r_errCode;
   logic [FRAME_W-1:0] r_frameIdx;
   logic [FRAME_W-1:0] r_frameCnt;
   logic [1:0]         r_mode;
   logic               r_startPrev;

   logic               w_inPhase;
   logic               w_expired;
   logic               w_frameEnd;
   logic               w_moreFrames;
   logic [FRAME_W:0]   w_nextIdx;
   state_t             w_startPhase;
   state_t             w_loopPhase;

   assign w_inPhase    = (r_state == S_RX) || (r_state == S_PROC) || (r_state == S_TX);
   assign w_startPhase = bus.mode[0] ? S_PROC : S_RX;
   assign w_loopPhase  = r_mode[0] ? S_PROC : S_RX;
   assign w_nextIdx    = {1'b0, r_frameIdx} + (FRAME_W+1)'(1);
   assign w_moreFrames = w_nextIdx < {1'b0, r_frameCnt};
   assign w_frameEnd   = ((r_state == S_PROC) && bus.end_process && r_mode[1]) ||
                         ((r_state == S_TX) && bus.tx_done);

   phase_watchdog #(
      .TO_W           (TO_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock     (clock),
      .reset_n   (reset_n),
      .i_clear   (r_rxStart | r_procStart | r_txStart),
      .i_enable  (w_inPhase),
      .o_expired (w_expired)
   );

   // Start detector resets high so a start held through reset needs a fresh edge.
   // Abort outranks done, and done outranks the watchdog expiry.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_status    <= STATUS_IDLE;
         r_led       <= LED_IDLE;
         r_rxStart   <= 1'b0;
         r_procStart <= 1'b0;
         r_txStart   <= 1'b0;
         r_runDone   <= 1'b0;
         r_errCode   <= ERR_NONE;
         r_frameIdx  <= '0;
         r_frameCnt  <= FRAME_W'(1);
         r_mode      <= 2'b00;
         r_startPrev <= 1'b1;
      end else begin
         r_startPrev <= bus.start_process;
         r_rxStart   <= 1'b0;
         r_procStart <= 1'b0;
         r_txStart   <= 1'b0;
         if (bus.abort && (r_state != S_IDLE)) begin
            r_state   <= S_IDLE;
            r_status  <= STATUS_IDLE;
            r_led     <= LED_IDLE;
            r_runDone <= 1'b0;
            r_errCode <= ERR_NONE;
         end else if (w_frameEnd) begin
            if (w_moreFrames) begin
               r_frameIdx  <= w_nextIdx[FRAME_W-1:0];
               r_state     <= w_loopPhase;
               r_status    <= statusOf(w_loopPhase);
               r_led       <= ledOf(w_loopPhase);
               r_rxStart   <= !r_mode[0];
               r_procStart <= r_mode[0];
            end else begin
               r_state   <= S_DONE;
               r_status  <= STATUS_IDLE;
               r_led     <= LED_DONE;
               r_runDone <= 1'b1;
            end
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (bus.start_process && !r_startPrev) begin
                     r_mode      <= bus.mode;
                     r_frameCnt  <= (bus.frame_count == '0) ? FRAME_W'(1) : bus.frame_count;
                     r_frameIdx  <= '0;
                     r_state     <= w_startPhase;
                     r_status    <= statusOf(w_startPhase);
                     r_led       <= ledOf(w_startPhase);
                     r_rxStart   <= !bus.mode[0];
                     r_procStart <= bus.mode[0];
                  end
               end
               S_RX: begin
                  if (bus.rx_done) begin
                     r_state     <= S_PROC;
                     r_status    <= STATUS_PROC;
                     r_led       <= LED_PROC;
                     r_procStart <= 1'b1;
                  end else if (w_expired) begin
                     r_state   <= S_ERROR;
                     r_status  <= STATUS_IDLE;
                     r_led     <= LED_ERROR;
                     r_errCode <= ERR_RX;
                  end
               end
               S_PROC: begin
                  if (bus.end_process) begin
                     r_state   <= S_TX;
                     r_status  <= STATUS_TX;
                     r_led     <= LED_TX;
                     r_txStart <= 1'b1;
                  end else if (w_expired) begin
                     r_state   <= S_ERROR;
                     r_status  <= STATUS_IDLE;
                     r_led     <= LED_ERROR;
                     r_errCode <= ERR_PROC;
                  end
               end
               S_TX: begin
                  if (w_expired) begin
                     r_state   <= S_ERROR;
                     r_status  <= STATUS_IDLE;
                     r_led     <= LED_ERROR;
                     r_errCode <= ERR_TX;
                  end
               end
               S_DONE: begin
                  if (!bus.start_process) begin
                     r_state   <= S_IDLE;
                     r_status  <= STATUS_IDLE;
                     r_led     <= LED_IDLE;
                     r_runDone <= 1'b0;
                  end
               end
               S_ERROR: begin
                  if (bus.clear_err) begin
                     r_state   <= S_IDLE;
                     r_status  <= STATUS_IDLE;
                     r_led     <= LED_IDLE;
                     r_errCode <= ERR_NONE;
                  end
               end
               default: begin
                  r_state  <= S_IDLE;
                  r_status <= STATUS_IDLE;
                  r_led    <= LED_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.rx_start   = r_rxStart;
   assign bus.proc_start = r_procStart;
   assign bus.tx_start   = r_txStart;
   assign bus.status     = r_status;
   assign bus.phase_led  = r_led;
   assign bus.frame_idx  = r_frameIdx;
   assign bus.run_done   = r_runDone;
   assign bus.err_code   = r_errCode;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: per-cycle vector table plus hand-written
// sequences for timeout, priority, abort and reset corners.
module tb_run_sequencer;

   logic clock;
   logic reset_n;
   int   testsRun;
   int   testsFailed;

   run_sequencer_if #(.FRAME_W(8)) bus ();

   run_sequencer #(
      .FRAME_W        (8),
      .TO_W           (24),
      .TIMEOUT_CYCLES (24'd16)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ctl = {abort, clear_err, rx_done, end_process, tx_done}; pulse = {rx, proc, tx}
   typedef struct {
      logic       start;
      logic [1:0] mode;
      logic [7:0] fcount;
      logic [4:0] ctl;
      logic [1:0] expStatus;
      logic [3:0] expLed;
      logic [2:0] expPulse;
      logic       expDone;
      logic [7:0] expIdx;
      logic [1:0] expErr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic st, input logic [1:0] md, input logic [7:0] fc,
                               input logic [4:0] ctl, input logic [1:0] es, input logic [3:0] el,
                               input logic [2:0] ep, input logic ed, input logic [7:0] ei,
                               input logic [1:0] ee);
      vec_t v;
      v.start = st; v.mode = md; v.fcount = fc; v.ctl = ctl;
      v.expStatus = es; v.expLed = el; v.expPulse = ep;
      v.expDone = ed; v.expIdx = ei; v.expErr = ee;
      return v;
   endfunction

   task automatic add(input vec_t v, input int n);
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic compare(input string what, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, act, exp);
      end
   endtask

   task automatic checkOutput(input string name, input logic [1:0] s, input logic [3:0] l,
                              input logic [2:0] p, input logic d, input logic [7:0] idx,
                              input logic [1:0] e);
      compare({name, ".status"},    32'(bus.status), 32'(s));
      compare({name, ".phase_led"}, 32'(bus.phase_led), 32'(l));
      compare({name, ".pulses"},    32'({bus.rx_start, bus.proc_start, bus.tx_start}), 32'(p));
      compare({name, ".run_done"},  32'(bus.run_done), 32'(d));
      compare({name, ".frame_idx"}, 32'(bus.frame_idx), 32'(idx));
      compare({name, ".err_code"},  32'(bus.err_code), 32'(e));
   endtask

   task automatic applyStimulus(input logic st, input logic [1:0] md, input logic [7:0] fc,
                                input logic [4:0] ctl);
      bus.start_process = st;
      bus.mode          = md;
      bus.frame_count   = fc;
      {bus.abort, bus.clear_err, bus.rx_done, bus.end_process, bus.tx_done} = ctl;
   endtask

   initial begin
      int cyc;
      testsRun    = 0;
      testsFailed = 0;
      reset_n     = 1'b0;
      applyStimulus(1'b0, 2'b00, 8'd1, 5'b00000);

      // Basic run, mode 00, one frame; stray done inputs outside their phase
      add(mk(1, 2'b00, 8'd1, 5'b00000, 2'b01, 4'b0010, 3'b100, 0, 0, 0), 1);
      add(mk(1, 2'b00, 8'd1, 5'b00000, 2'b01, 4'b0010, 3'b000, 0, 0, 0), 3);
      add(mk(1, 2'b00, 8'd1, 5'b00011, 2'b01, 4'b0010, 3'b000, 0, 0, 0), 1);
      add(mk(1, 2'b00, 8'd1, 5'b00100, 2'b10, 4'b0100, 3'b010, 0, 0, 0), 1);
      add(mk(1, 2'b00, 8'd1, 5'b00000, 2'b10, 4'b0100, 3'b000, 0, 0, 0), 7);
      add(mk(1, 2'b00, 8'd1, 5'b00010, 2'b11, 4'b1000, 3'b001, 0, 0, 0), 1);
      add(mk(1, 2'b00, 8'd1, 5'b00100, 2'b11, 4'b1000, 3'b000, 0, 0, 0), 2);
      add(mk(1, 2'b00, 8'd1, 5'b00001, 2'b00, 4'b1111, 3'b000, 1, 0, 0), 1);
      add(mk(1, 2'b00, 8'd1, 5'b00000, 2'b00, 4'b1111, 3'b000, 1, 0, 0), 1);
      add(mk(0, 2'b00, 8'd1, 5'b00000, 2'b00, 4'b0001, 3'b000, 0, 0, 0), 1);
      // frame_count 0 runs a single frame
      add(mk(1, 2'b00, 8'd0, 5'b00000, 2'b01, 4'b0010, 3'b100, 0, 0, 0), 1);
      add(mk(1, 2'b00, 8'd0, 5'b00100, 2'b10, 4'b0100, 3'b010, 0, 0, 0), 1);
      add(mk(1, 2'b00, 8'd0, 5'b00010, 2'b11, 4'b1000, 3'b001, 0, 0, 0), 1);
      add(mk(1, 2'b00, 8'd0, 5'b00001, 2'b00, 4'b1111, 3'b000, 1, 0, 0), 1);
      add(mk(0, 2'b00, 8'd0, 5'b00000, 2'b00, 4'b0001, 3'b000, 0, 0, 0), 1);
      // Full bypass, three frames, PROC only
      add(mk(1, 2'b11, 8'd3, 5'b00000, 2'b10, 4'b0100, 3'b010, 0, 0, 0), 1);
      add(mk(1, 2'b11, 8'd3, 5'b00010, 2'b10, 4'b0100, 3'b010, 0, 1, 0), 1);
      add(mk(1, 2'b11, 8'd3, 5'b00101, 2'b10, 4'b0100, 3'b000, 0, 1, 0), 1);
      add(mk(1, 2'b11, 8'd3, 5'b00010, 2'b10, 4'b0100, 3'b010, 0, 2, 0), 1);
      add(mk(1, 2'b11, 8'd3, 5'b00010, 2'b00, 4'b1111, 3'b000, 1, 2, 0), 1);
      add(mk(0, 2'b11, 8'd3, 5'b00000, 2'b00, 4'b0001, 3'b000, 0, 2, 0), 1);

      repeat (2) @(posedge clock);
      #1;
      checkOutput("reset", 2'b00, 4'b0001, 3'b000, 0, 0, 0);
      reset_n = 1'b1;
      tick();
      checkOutput("idle", 2'b00, 4'b0001, 3'b000, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].start, vecs[i].mode, vecs[i].fcount, vecs[i].ctl);
         tick();
         checkOutput($sformatf("vec%0d", i), vecs[i].expStatus, vecs[i].expLed,
                     vecs[i].expPulse, vecs[i].expDone, vecs[i].expIdx, vecs[i].expErr);
      end

      // Timeout in PROC: ERROR exactly 16 cycles after entry
      applyStimulus(1, 2'b00, 8'd1, 5'b00000);
      tick();
      applyStimulus(1, 2'b00, 8'd1, 5'b00100);
      tick();
      checkOutput("to_entry", 2'b10, 4'b0100, 3'b010, 0, 0, 0);
      applyStimulus(1, 2'b00, 8'd1, 5'b00000);
      cyc = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (bus.phase_led == 4'b1001) begin
            cyc = k;
            break;
         end
      end
      compare("timeout_latency", 32'(cyc), 32'd16);
      checkOutput("to_error", 2'b00, 4'b1001, 3'b000, 0, 0, 2'b10);
      applyStimulus(0, 2'b00, 8'd1, 5'b00000);
      tick();
      applyStimulus(1, 2'b00, 8'd1, 5'b00000);
      tick();
      tick();
      checkOutput("to_ignore_start", 2'b00, 4'b1001, 3'b000, 0, 0, 2'b10);
      applyStimulus(1, 2'b00, 8'd1, 5'b01000);
      tick();
      checkOutput("to_clear", 2'b00, 4'b0001, 3'b000, 0, 0, 0);
      applyStimulus(1, 2'b00, 8'd1, 5'b00000);
      tick();
      checkOutput("to_no_restart", 2'b00, 4'b0001, 3'b000, 0, 0, 0);
      applyStimulus(0, 2'b00, 8'd1, 5'b00000);
      tick();

      // Done on the expiry cycle wins over timeout
      applyStimulus(1, 2'b00, 8'd1, 5'b00000);
      tick();
      checkOutput("dt_entry", 2'b01, 4'b0010, 3'b100, 0, 0, 0);
      repeat (15) tick();
      checkOutput("dt_last", 2'b01, 4'b0010, 3'b000, 0, 0, 0);
      applyStimulus(1, 2'b00, 8'd1, 5'b00100);
      tick();
      checkOutput("dt_next", 2'b10, 4'b0100, 3'b010, 0, 0, 0);
      applyStimulus(1, 2'b00, 8'd1, 5'b10000);
      tick();
      checkOutput("dt_abort", 2'b00, 4'b0001, 3'b000, 0, 0, 0);
      applyStimulus(0, 2'b00, 8'd1, 5'b00000);
      tick();

      // Abort with tx_done on a two-frame run: idle, index not advanced
      applyStimulus(1, 2'b00, 8'd2, 5'b00000);
      tick();
      applyStimulus(1, 2'b00, 8'd2, 5'b00100);
      tick();
      applyStimulus(1, 2'b00, 8'd2, 5'b00010);
      tick();
      checkOutput("ab_tx", 2'b11, 4'b1000, 3'b001, 0, 0, 0);
      applyStimulus(1, 2'b00, 8'd2, 5'b10001);
      tick();
      checkOutput("ab_idle", 2'b00, 4'b0001, 3'b000, 0, 0, 0);
      applyStimulus(0, 2'b00, 8'd2, 5'b00000);
      tick();

      // Reset mid-PROC with start held high, then a fresh edge is needed
      applyStimulus(1, 2'b11, 8'd3, 5'b00000);
      tick();
      applyStimulus(1, 2'b11, 8'd3, 5'b00010);
      tick();
      checkOutput("rs_frame1", 2'b10, 4'b0100, 3'b010, 0, 1, 0);
      applyStimulus(1, 2'b11, 8'd3, 5'b00000);
      reset_n = 1'b0;
      #1;
      checkOutput("rs_async", 2'b00, 4'b0001, 3'b000, 0, 0, 0);
      #2;
      reset_n = 1'b1;
      tick();
      tick();
      checkOutput("rs_held", 2'b00, 4'b0001, 3'b000, 0, 0, 0);
      applyStimulus(0, 2'b11, 8'd3, 5'b00000);
      tick();
      applyStimulus(1, 2'b11, 8'd3, 5'b00000);
      tick();
      checkOutput("rs_restart", 2'b10, 4'b0100, 3'b010, 0, 0, 0);
      applyStimulus(1, 2'b11, 8'd3, 5'b10000);
      tick();
      applyStimulus(0, 2'b00, 8'd1, 5'b00000);
      tick();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Parametrised top-level run controller for the down-sampling processor system; next generation of the fixed four-state main controller.
- Sequences each frame through RX (load image into dram), PROC (Processor runs until end_process) and TX (stream result out); repeats for a programmable frame count.
- Adds per-phase start pulses and done handshakes, mode-selectable phase bypass, a per-phase watchdog timeout with error reporting, and abort.
- status drives slowclock clock selection; phase_led replaces s0..s3.

Parameters:
- FRAME_W, 8, width of frame_count and frame_idx.
- TO_W, 24, watchdog counter width.
- TIMEOUT_CYCLES, 24'd10_000_000, cycles allowed per phase before error; 0 disables the watchdog.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start_process  in  1  run request, level; a rising edge starts a run
- mode  in  2  bit0=skip RX, bit1=skip TX; latched at run start
- frame_count  in  FRAME_W  frames per run; latched at run start; 0 treated as 1
- abort  in  1  synchronous abort
- clear_err  in  1  leave ERROR state
- rx_done  in  1  RX phase complete
- end_process  in  1  PROC phase complete
- tx_done  in  1  TX phase complete
- rx_start  out  1  one-cycle pulse on RX entry
- proc_start  out  1  one-cycle pulse on PROC entry
- tx_start  out  1  one-cycle pulse on TX entry
- status  out  2  IDLE/DONE/ERROR=00, RX=01, PROC=10, TX=11
- phase_led  out  4  IDLE=0001, RX=0010, PROC=0100, TX=1000, DONE=1111, ERROR=1001
- frame_idx  out  FRAME_W  current frame index
- run_done  out  1  high while in DONE
- err_code  out  2  phase that timed out (01 RX, 10 PROC, 11 TX); 00 otherwise

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE; all pulses 0; status 00; phase_led 0001.
  - frame_idx 0, err_code 0, run_done 0, watchdog 0.
  - The start edge detector register resets to 1, so a start_process held high through reset does not start a run.
- States: IDLE, RX, PROC, TX, DONE, ERROR; all outputs registered.
- IDLE:
  - On a start_process rising edge (registered previous value), latch mode and frame_count (0 becomes 1) and set frame_idx=0.
  - Enter the first enabled phase: RX, or PROC when mode[0]=1.
- Phase entry:
  - The matching *_start pulse is high exactly in the first cycle the new state is visible on status.
  - The watchdog clears to 0.
- In a phase:
  - The watchdog increments each cycle.
  - A high matching done input moves to the next state in the following cycle.
  - Done inputs are ignored outside their own phase.
- Phase order:
  - RX→PROC.
  - PROC→TX, or end-of-frame when mode[1]=1.
  - TX→end-of-frame.
- End-of-frame:
  - If frame_idx+1 < latched count: frame_idx increments, then enter the first enabled phase again (new start pulse).
  - Otherwise enter DONE with frame_idx unchanged.
- Timeout: if TIMEOUT_CYCLES≠0 and the watchdog reaches TIMEOUT_CYCLES-1 with no done, enter ERROR and set err_code to the phase id.
- DONE: run_done=1; return to IDLE when start_process is low; frame_idx is held until the next run.
- ERROR: held until clear_err=1, then IDLE with err_code cleared; start_process is ignored while in ERROR.
- Priority in the same cycle: abort > done > timeout.
- abort in any state except IDLE: IDLE next cycle; pulses 0, run_done 0, err_code 0.
- Reset mid-run: immediate IDLE; no start pulse is emitted.

Decomposition:
- Shared package run_pkg:
  - state enum;
  - STATUS_* encodings (shared with slowclock);
  - LED_* patterns;
  - ERR_* codes.
- One sub-module, phase_watchdog: counter, clear, enable and expiry flag, parametrised by TO_W/TIMEOUT_CYCLES.

Test Plan:
- Basic run: mode=00, frame_count=1, start rises; rx_done after 5 cycles, end_process after 8, tx_done after 3. Required: status 01→10→11→00, one pulse each on rx_start/proc_start/tx_start, run_done=1, phase_led=1111. Drop start → IDLE, led 0001.
- Bypass: mode=11, frame_count=3. Required: only proc_start pulses, three times; frame_idx 0,1,2; DONE after the third end_process; rx_start/tx_start never assert.
- Timeout: TIMEOUT_CYCLES=16, no end_process. Required: ERROR exactly 16 cycles after PROC entry, err_code=10, led=1001; start ignored; clear_err → IDLE, err_code 00.
- Abort and priority: abort and tx_done in the same cycle → IDLE, frame_idx not incremented. Done and timeout in the same cycle → next phase, no error.
- Reset: reset_n low mid-PROC → immediate IDLE defaults. Reset released with start_process held high → no run until start toggles low then high.
- Frame count 0: frame_count=0 behaves as 1 frame (single pass, then DONE).
